// File: rtl/stack_pc_if.sv
// stack_pc_if: control/status bundle for stack_pc_param
// master drives push/pop/jump/jump_addr/pc_inc/pc_load/pc_sel/data_in/err_clr;
// slave returns data_out/pc/depth/full/empty/ovf_err/udf_err.
interface stack_pc_if #(
    parameter int NIBBLES = 3,
    parameter int DEPTH   = 8
);
    localparam int PW = 4 * NIBBLES;
    localparam int SW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic          push;
    logic          pop;
    logic          jump;
    logic [PW-1:0] jump_addr;
    logic          pc_inc;
    logic          pc_load;
    logic [SW-1:0] pc_sel;
    logic [3:0]    data_in;
    logic          err_clr;
    logic [3:0]    data_out;
    logic [PW-1:0] pc;
    logic [CW-1:0] depth;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          udf_err;
    modport master (
        output push, pop, jump, jump_addr, pc_inc, pc_load, pc_sel, data_in, err_clr,
        input  data_out, pc, depth, full, empty, ovf_err, udf_err
    );
    modport slave (
        input  push, pop, jump, jump_addr, pc_inc, pc_load, pc_sel, data_in, err_clr,
        output data_out, pc, depth, full, empty, ovf_err, udf_err
    );
endinterface

// File: rtl/stack_pc_param.sv
// stack_pc_param: nibble-addressable program counter with a call/return stack
// clk, reset_n (sync, active-low); bus (slave): one operation per cycle,
// priority pc_load > push(+jump) > pop > jump > pc_inc; sticky ovf/udf flags.
module stack_pc_param #(
    parameter int NIBBLES   = 3,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 0
) (
    input logic        clk,
    input logic        reset_n,
    stack_pc_if.slave  bus
);
    localparam int PW = 4 * NIBBLES;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    logic [PW-1:0] stack [DEPTH];
    logic [PW-1:0] pc;
    logic [PW-1:0] top;
    logic [CW-1:0] depth;
    logic [3:0]    nib;
    logic          ovf, udf, full, empty;
    assign full  = depth == CW'(DEPTH);
    assign empty = depth == '0;
    // Newest entry lives at index depth-1; out-of-range selects read as zero.
    always_comb begin
        top = '0;
        nib = '0;
        for (int i = 0; i < DEPTH; i++)
            if (depth == CW'(i + 1)) top = stack[i];
        for (int n = 0; n < NIBBLES; n++)
            if (bus.pc_sel == SW'(n)) nib = pc[n*4 +: 4];
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc    <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            // Clear first so a same-cycle set event below takes precedence.
            if (bus.err_clr) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
            if (bus.pc_load) begin
                for (int n = 0; n < NIBBLES; n++)
                    if (bus.pc_sel == SW'(n)) pc[n*4 +: 4] <= bus.data_in;
            end else if (bus.push) begin
                if (!full) begin
                    for (int i = 0; i < DEPTH; i++)
                        if (depth == CW'(i)) stack[i] <= pc;
                    depth <= depth + CW'(1);
                    if (bus.jump) pc <= bus.jump_addr;
                end else begin
                    ovf <= 1'b1;
                    if (WRAP_MODE != 0) begin
                        for (int i = 0; i < DEPTH - 1; i++) stack[i] <= stack[i+1];
                        stack[DEPTH-1] <= pc;
                        if (bus.jump) pc <= bus.jump_addr;
                    end
                end
            end else if (bus.pop) begin
                if (!empty) begin
                    pc    <= top;
                    depth <= depth - CW'(1);
                end else begin
                    udf <= 1'b1;
                end
            end else if (bus.jump) begin
                pc <= bus.jump_addr;
            end else if (bus.pc_inc) begin
                pc <= pc + PW'(1);
            end
        end
    end
    assign bus.pc       = pc;
    assign bus.depth    = depth;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.ovf_err  = ovf;
    assign bus.udf_err  = udf;
    assign bus.data_out = nib;
endmodule

// File: tb/tb_stack_pc_param.sv
// tb_stack_pc_param: scoreboard bench for two stack_pc_param configurations
module tb_stack_pc_param;
    localparam int S_PC = 0, S_DEPTH = 1, S_FULL = 2, S_EMPTY = 3, S_OVF = 4, S_UDF = 5, S_DOUT = 6;
    typedef struct {
        string       tag;
        int          dut;
        int          sig;
        logic [31:0] exp;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    stack_pc_if #(.NIBBLES(3), .DEPTH(8)) ia ();
    stack_pc_if #(.NIBBLES(3), .DEPTH(3)) ib ();
    stack_pc_param #(.NIBBLES(3), .DEPTH(8), .WRAP_MODE(0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
    stack_pc_param #(.NIBBLES(3), .DEPTH(3), .WRAP_MODE(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] obs(input int d, input int s);
        if (d == 0)
            case (s)
                S_PC:    return 32'(ia.pc);
                S_DEPTH: return 32'(ia.depth);
                S_FULL:  return 32'(ia.full);
                S_EMPTY: return 32'(ia.empty);
                S_OVF:   return 32'(ia.ovf_err);
                S_UDF:   return 32'(ia.udf_err);
                default: return 32'(ia.data_out);
            endcase
        case (s)
            S_PC:    return 32'(ib.pc);
            S_DEPTH: return 32'(ib.depth);
            S_FULL:  return 32'(ib.full);
            S_EMPTY: return 32'(ib.empty);
            S_OVF:   return 32'(ib.ovf_err);
            S_UDF:   return 32'(ib.udf_err);
            default: return 32'(ib.data_out);
        endcase
    endfunction
    task automatic expect_val(input string tag, input int d, input int s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.dut = d;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.dut, e.sig), e.exp);
        end
    endtask
    task automatic cycle();
        @(posedge clk);
        #1;
        drain();
    endtask
    task automatic settle();
        #1;
        drain();
    endtask
    task automatic idle();
        {ia.push, ia.pop, ia.jump, ia.pc_inc, ia.pc_load, ia.err_clr} = '0;
        {ib.push, ib.pop, ib.jump, ib.pc_inc, ib.pc_load, ib.err_clr} = '0;
        ia.jump_addr = '0; ia.pc_sel = '0; ia.data_in = '0;
        ib.jump_addr = '0; ib.pc_sel = '0; ib.data_in = '0;
    endtask
    initial begin
        idle();
        reset_n = 1'b0;
        ia.push = 1'b1;
        ib.push = 1'b1;
        ib.pop  = 1'b1;
        expect_val("rst_pc", 0, S_PC, 0);
        expect_val("rst_depth", 0, S_DEPTH, 0);
        expect_val("rst_empty", 0, S_EMPTY, 1);
        expect_val("rst_full", 0, S_FULL, 0);
        expect_val("rst_ovf", 0, S_OVF, 0);
        expect_val("rst_udf", 0, S_UDF, 0);
        expect_val("rst_b_depth", 1, S_DEPTH, 0);
        expect_val("rst_b_udf", 1, S_UDF, 0);
        cycle();
        cycle();
        reset_n = 1'b1;
        idle();
        ia.pc_inc = 1'b1;
        repeat (4094) cycle();
        expect_val("inc_max", 0, S_PC, 32'hfff);
        cycle();
        expect_val("inc_wrap", 0, S_PC, 0);
        expect_val("inc_depth", 0, S_DEPTH, 0);
        expect_val("inc_empty", 0, S_EMPTY, 1);
        cycle();
        idle();
        ia.jump = 1'b1; ia.jump_addr = 12'h123;
        expect_val("jump_pc", 0, S_PC, 32'h123);
        cycle();
        ia.push = 1'b1; ia.jump_addr = 12'h456;
        expect_val("call_pc", 0, S_PC, 32'h456);
        expect_val("call_depth", 0, S_DEPTH, 1);
        cycle();
        idle();
        ia.pop = 1'b1;
        expect_val("ret_pc", 0, S_PC, 32'h123);
        expect_val("ret_depth", 0, S_DEPTH, 0);
        cycle();
        idle();
        ia.jump = 1'b1;
        cycle();
        idle();
        ia.pc_load = 1'b1; ia.push = 1'b1; ia.pc_inc = 1'b1; ia.pc_sel = 2'd1; ia.data_in = 4'ha;
        expect_val("load_pc", 0, S_PC, 32'h0a0);
        expect_val("load_depth", 0, S_DEPTH, 0);
        cycle();
        idle();
        ia.pc_load = 1'b1; ia.pc_sel = 2'd3; ia.data_in = 4'h5;
        expect_val("load_sel3_pc", 0, S_PC, 32'h0a0);
        cycle();
        idle();
        ia.pc_sel = 2'd3;
        expect_val("dout_sel3", 0, S_DOUT, 0);
        settle();
        ia.pc_sel = 2'd1;
        expect_val("dout_sel1", 0, S_DOUT, 32'ha);
        settle();
        ia.pc_sel = 2'd2;
        expect_val("dout_sel2", 0, S_DOUT, 0);
        settle();
        idle();
        ia.jump = 1'b1; ia.jump_addr = '0;
        cycle();
        idle();
        for (int v = 0; v < 9; v++) begin
            ia.push = 1'b1; ia.jump = 1'b1; ia.jump_addr = 12'(v + 1);
            expect_val($sformatf("fill_depth%0d", v), 0, S_DEPTH, (v < 8) ? v + 1 : 8);
            expect_val($sformatf("fill_pc%0d", v), 0, S_PC, (v < 8) ? v + 1 : 8);
            cycle();
        end
        idle();
        expect_val("fill_full", 0, S_FULL, 1);
        expect_val("fill_ovf", 0, S_OVF, 1);
        settle();
        ia.pop = 1'b1;
        for (int v = 7; v >= 0; v--) begin
            expect_val($sformatf("drain_pc%0d", v), 0, S_PC, v);
            expect_val($sformatf("drain_depth%0d", v), 0, S_DEPTH, v);
            cycle();
        end
        expect_val("drain_empty", 0, S_EMPTY, 1);
        expect_val("drain_full", 0, S_FULL, 0);
        expect_val("ovf_sticky", 0, S_OVF, 1);
        expect_val("udf_pre", 0, S_UDF, 0);
        settle();
        expect_val("udf_pc", 0, S_PC, 0);
        expect_val("udf_depth", 0, S_DEPTH, 0);
        expect_val("udf_set", 0, S_UDF, 1);
        cycle();
        idle();
        ia.err_clr = 1'b1;
        expect_val("clr_ovf", 0, S_OVF, 0);
        expect_val("clr_udf", 0, S_UDF, 0);
        cycle();
        ia.pop = 1'b1;
        expect_val("clr_pop_udf", 0, S_UDF, 1);
        expect_val("clr_pop_ovf", 0, S_OVF, 0);
        cycle();
        idle();
        ib.jump = 1'b1; ib.jump_addr = 12'h1;
        cycle();
        for (int v = 1; v <= 3; v++) begin
            ib.push = 1'b1; ib.jump = 1'b1; ib.jump_addr = 12'(v + 1);
            expect_val($sformatf("b_push_depth%0d", v), 1, S_DEPTH, v);
            cycle();
        end
        ib.jump_addr = 12'h9;
        expect_val("b_wrap_depth", 1, S_DEPTH, 3);
        expect_val("b_wrap_ovf", 1, S_OVF, 1);
        expect_val("b_wrap_pc", 1, S_PC, 32'h9);
        expect_val("b_wrap_full", 1, S_FULL, 1);
        cycle();
        idle();
        ib.pop = 1'b1;
        for (int v = 4; v >= 2; v--) begin
            expect_val($sformatf("b_pop_pc%0d", v), 1, S_PC, v);
            expect_val($sformatf("b_pop_depth%0d", v), 1, S_DEPTH, v - 2);
            cycle();
        end
        expect_val("b_udf_pc", 1, S_PC, 2);
        expect_val("b_udf_set", 1, S_UDF, 1);
        cycle();
        idle();
        ib.push = 1'b1; ib.jump = 1'b1; ib.jump_addr = 12'h77;
        cycle();
        expect_val("b_pre_rst_depth", 1, S_DEPTH, 1);
        settle();
        reset_n = 1'b0;
        expect_val("b_midrst_pc", 1, S_PC, 0);
        expect_val("b_midrst_depth", 1, S_DEPTH, 0);
        expect_val("b_midrst_udf", 1, S_UDF, 0);
        expect_val("b_midrst_ovf", 1, S_OVF, 0);
        cycle();
        reset_n = 1'b1;
        idle();
        cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
